// File: rtl/uart_image_loader.sv
// uart_image_loader
//   Frame controller between the UART receiver and the on-chip image memory.
//   A frame is: SYNC_BYTE, IMG_W*IMG_H pixel bytes (written to addresses
//   0..IMG_W*IMG_H-1), then one checksum byte equal to the 8-bit sum of the
//   pixels. A good frame is held (img_valid=1, host throttled via
//   fpga_can_receive=0) until the detector pulses img_consumed. A bad checksum
//   or an inter-byte gap longer than TIMEOUT_CYC aborts the frame with a
//   one-cycle img_err pulse.
//
// Ports
//   clock            in   system clock, rising edge
//   reset_n          in   asynchronous active-low reset
//   byte_rdy         in   one-cycle strobe, byte_data valid
//   byte_data[7:0]   in   received byte
//   img_consumed     in   one-cycle pulse from detector, releases held image
//   mem_we           out  image memory write enable (one cycle per pixel)
//   mem_addr         out  image memory write address
//   mem_wdata[7:0]   out  image memory write data
//   fpga_can_receive out  RTS to host, 1 = host may send
//   img_valid        out  complete, checksum-correct image in memory
//   img_err          out  one-cycle pulse, frame aborted
//   busy             out  frame in progress (RECV or CHECK)
//   state_dbg[2:0]   out  current FSM state (IDLE=0 RECV=1 CHECK=2 DONE=3 ERROR=4)
//
// Handshake: byte_rdy is a pure valid strobe with no back-pressure; every
// strobe is consumed on the clock edge that samples it. Flow control toward
// the host is only the fpga_can_receive level.
module uart_image_loader #(
  parameter int unsigned IMG_W       = 40,
  parameter int unsigned IMG_H       = 30,
  parameter int unsigned ADDR_W      = 11,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter logic [31:0] TIMEOUT_CYC = 32'd65536
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              byte_rdy,
  input  logic [7:0]        byte_data,
  input  logic              img_consumed,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              fpga_can_receive,
  output logic              img_valid,
  output logic              img_err,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_CHECK = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pix_cnt;
  logic [7:0]        sum;
  logic [31:0]       gap_cnt;

  logic sync_hit;
  logic pix_write;
  logic in_frame;
  logic timed_out;

  assign sync_hit  = (state == S_IDLE) && byte_rdy && (byte_data == SYNC_BYTE);
  assign pix_write = (state == S_RECV) && byte_rdy;
  assign in_frame  = (state == S_RECV) || (state == S_CHECK);
  // A byte arriving on the same cycle the gap limit is reached takes priority.
  assign timed_out = (gap_cnt == TIMEOUT_CYC) && !byte_rdy;
  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (sync_hit) state_next = S_RECV;
      end
      S_RECV: begin
        if (byte_rdy) begin
          if (pix_cnt == LAST_PIX) state_next = S_CHECK;
        end else if (timed_out) begin
          state_next = S_ERROR;
        end
      end
      S_CHECK: begin
        if (byte_rdy) begin
          state_next = (byte_data == sum) ? S_DONE : S_ERROR;
        end else if (timed_out) begin
          state_next = S_ERROR;
        end
      end
      S_DONE: begin
        if (img_consumed) state_next = S_IDLE;
      end
      S_ERROR: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs. Status outputs are registered copies of
  // the next-state decode so they line up with the state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt          <= '0;
      sum              <= '0;
      gap_cnt          <= '0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      fpga_can_receive <= 1'b1;
      img_valid        <= 1'b0;
      img_err          <= 1'b0;
      busy             <= 1'b0;
    end else begin
      mem_we <= pix_write;
      if (pix_write) begin
        mem_addr  <= pix_cnt;
        mem_wdata <= byte_data;
      end

      if (sync_hit) begin
        pix_cnt <= '0;
        sum     <= '0;
      end else if (pix_write) begin
        sum <= sum + byte_data;
        // Hold at the last address; the frame leaves RECV on this strobe.
        if (pix_cnt != LAST_PIX) pix_cnt <= pix_cnt + ADDR_W'(1);
      end

      // Gap counter only runs inside a frame; IDLE keeps it cleared so RECV
      // is always entered with a fresh count.
      if (in_frame) begin
        if (byte_rdy) begin
          gap_cnt <= '0;
        end else if (gap_cnt != TIMEOUT_CYC) begin
          gap_cnt <= gap_cnt + 32'd1;
        end
      end else begin
        gap_cnt <= '0;
      end

      fpga_can_receive <= (state_next != S_DONE);
      img_valid        <= (state_next == S_DONE);
      img_err          <= (state_next == S_ERROR);
      busy             <= (state_next == S_RECV) || (state_next == S_CHECK);
    end
  end

endmodule

// File: tb/tb_uart_image_loader.sv
module tb_uart_image_loader;

  localparam int          ADDR_W = 11;
  localparam int          NPIX   = 1200;
  localparam logic [7:0]  SYNC   = 8'hA5;
  localparam logic [31:0] TMO    = 32'd300;

  // clock / reset
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic              byte_rdy;
  logic [7:0]        byte_data;
  logic              img_consumed;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              fpga_can_receive;
  logic              img_valid;
  logic              img_err;
  logic              busy;
  logic [2:0]        state_dbg;

  uart_image_loader #(
    .IMG_W(40), .IMG_H(30), .ADDR_W(ADDR_W), .SYNC_BYTE(SYNC), .TIMEOUT_CYC(TMO)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .byte_rdy(byte_rdy),
    .byte_data(byte_data),
    .img_consumed(img_consumed),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .fpga_can_receive(fpga_can_receive),
    .img_valid(img_valid),
    .img_err(img_err),
    .busy(busy),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [ADDR_W+7:0] exp_q[$];
  logic [7:0]        run_sum;
  logic [ADDR_W-1:0] next_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every memory write must match the head of the expected queue
  always @(negedge clock) begin : mon
    logic [ADDR_W+7:0] e;
    if (reset_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {31'b0, mem_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {21'b0, mem_addr}, {21'b0, e[ADDR_W+7:8]});
        chk("write_data", {24'b0, mem_wdata}, {24'b0, e[7:0]});
      end
    end
  end

  // driver tasks: every task starts and ends 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] d);
    byte_rdy  = 1'b1;
    byte_data = d;
    @(posedge clock); #1;
    byte_rdy  = 1'b0;
    byte_data = 8'($urandom_range(0, 255));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_sync();
    run_sum   = 8'h00;
    next_addr = '0;
    send_byte(SYNC);
  endtask

  function automatic logic [7:0] pix(input int mode, input int i);
    logic [7:0] v;
    v = 8'(i);
    if (mode == 1) begin
      v = 8'(i * 7 + 3);
      if (i == 0 || i == 5 || i == 600 || i == NPIX - 1) v = SYNC;
    end else if (mode == 2) begin
      v = 8'(i * 13 + 91);
    end
    return v;
  endfunction

  task automatic send_pixels(input int mode, input int first, input int last);
    logic [7:0] d;
    for (int i = first; i <= last; i++) begin
      d = pix(mode, i);
      exp_q.push_back({next_addr, d});
      run_sum   = run_sum + d;
      next_addr = next_addr + 1'b1;
      send_byte(d);
      if (mode == 2 && (i % 97) == 0) idle($urandom_range(1, 5));
    end
  endtask

  task automatic consume();
    img_consumed = 1'b1;
    @(posedge clock); #1;
    img_consumed = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, {21'b0, mem_addr}, 32'd0);
    chk({tag, "_mem_wdata"}, {24'b0, mem_wdata}, 32'd0);
    chk({tag, "_can_receive"}, {31'b0, fpga_can_receive}, 32'd1);
    chk({tag, "_img_valid"}, {31'b0, img_valid}, 32'd0);
    chk({tag, "_img_err"}, {31'b0, img_err}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_state"}, {29'b0, state_dbg}, 32'd0);
  endtask

  task automatic check_done(input string tag);
    chk({tag, "_img_valid"}, {31'b0, img_valid}, 32'd1);
    chk({tag, "_can_receive"}, {31'b0, fpga_can_receive}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_q_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    byte_rdy     = 1'b0;
    byte_data    = 8'h00;
    img_consumed = 1'b0;
    idle(3);
    check_reset_values("reset");
    reset_n = 1'b1;
    idle(2);

    // nominal frame, back-to-back bytes
    send_sync();
    chk("nom_busy_after_sync", {31'b0, busy}, 32'd1);
    send_pixels(0, 0, NPIX - 1);
    chk("nom_state_check", {29'b0, state_dbg}, 32'd2);
    chk("nom_busy_in_check", {31'b0, busy}, 32'd1);
    chk("nom_valid_before_cks", {31'b0, img_valid}, 32'd0);
    send_byte(run_sum);
    check_done("nom");

    // hold: bytes in DONE are ignored, then release
    send_byte(SYNC);
    send_byte(8'h42);
    idle(2);
    send_byte(8'h17);
    idle(2);
    chk("hold_img_valid", {31'b0, img_valid}, 32'd1);
    chk("hold_can_receive", {31'b0, fpga_can_receive}, 32'd0);
    consume();
    chk("release_img_valid", {31'b0, img_valid}, 32'd0);
    chk("release_can_receive", {31'b0, fpga_can_receive}, 32'd1);
    consume();
    chk("idle_consume_ignored", {29'b0, state_dbg}, 32'd0);

    // bad checksum
    send_sync();
    send_pixels(0, 0, NPIX - 1);
    send_byte(run_sum ^ 8'h01);
    chk("badcks_img_err", {31'b0, img_err}, 32'd1);
    chk("badcks_img_valid", {31'b0, img_valid}, 32'd0);
    idle(1);
    chk("badcks_err_cleared", {31'b0, img_err}, 32'd0);
    chk("badcks_can_receive", {31'b0, fpga_can_receive}, 32'd1);
    chk("badcks_busy", {31'b0, busy}, 32'd0);
    chk("badcks_q_empty", exp_q.size(), 32'd0);

    // noise before sync, 0xA5 inside the pixel data
    send_byte(8'h00);
    idle(1);
    send_byte(8'h13);
    idle(1);
    chk("noise_not_busy", {31'b0, busy}, 32'd0);
    send_sync();
    send_pixels(1, 0, NPIX - 1);
    send_byte(run_sum);
    check_done("resync");
    consume();

    // timeout after 10 pixels
    send_sync();
    send_pixels(2, 0, 9);
    idle(TMO);
    chk("tmo_no_err_yet", {31'b0, img_err}, 32'd0);
    chk("tmo_busy_yet", {31'b0, busy}, 32'd1);
    idle(1);
    chk("tmo_img_err", {31'b0, img_err}, 32'd1);
    idle(1);
    chk("tmo_err_cleared", {31'b0, img_err}, 32'd0);
    chk("tmo_can_receive", {31'b0, fpga_can_receive}, 32'd1);
    chk("tmo_idle", {29'b0, state_dbg}, 32'd0);

    // byte lands on the timeout cycle: byte wins, frame continues
    send_sync();
    send_pixels(2, 0, 9);
    idle(TMO);
    send_pixels(2, 10, 10);
    chk("tmo_edge_no_err", {31'b0, img_err}, 32'd0);
    chk("tmo_edge_busy", {31'b0, busy}, 32'd1);
    idle(2);
    chk("tmo_edge_still_busy", {31'b0, busy}, 32'd1);
    send_pixels(2, 11, NPIX - 1);
    idle(TMO);
    send_byte(run_sum);
    check_done("tmo_edge");
    consume();

    // async reset in the middle of RECV
    send_sync();
    send_pixels(0, 0, 49);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_q.delete();
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(3);
    chk("midreset_no_err", {31'b0, img_err}, 32'd0);
    send_sync();
    send_pixels(2, 0, NPIX - 1);
    send_byte(run_sum);
    check_done("after_reset");
    consume();
    idle(3);
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
